// File: rtl/dmem_if.sv
// Initiator-side data-memory port: address, write data, strobes and returned read data.
interface dmem_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_access_addr,
        output mem_write_data,
        output mem_write,
        output mem_read,
        input  mem_read_data
    );

    modport slave (
        input  mem_access_addr,
        input  mem_write_data,
        input  mem_write,
        input  mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_dma_engine.sv
// Block-transfer engine for the data-memory port: word copy (memory to memory)
// or constant fill of a programmed length, one word per access.
module dmem_dma_engine #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] fill_value,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_done,
    dmem_if.master            mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              mode_q;
    logic [ADDR_W-1:0] src_ptr_q;
    logic [ADDR_W-1:0] dst_ptr_q;
    logic [LEN_W-1:0]  remaining_q;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] buf_q;

    // State register; reset returns to IDLE at once so every strobe drops asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and memory-port decode from the registered state.
    always_comb begin
        state_d             = state_q;
        busy                = 1'b0;
        done                = 1'b0;
        mem.mem_access_addr = '0;
        mem.mem_write_data  = '0;
        mem.mem_write       = 1'b0;
        mem.mem_read        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length == '0) state_d = S_DONE;
                    else if (mode)    state_d = S_WR;
                    else              state_d = S_RD;
                end
            end
            S_RD: begin
                busy                = 1'b1;
                mem.mem_read        = 1'b1;
                mem.mem_access_addr = src_ptr_q;
                state_d             = abort ? S_DONE : S_WR;
            end
            S_WR: begin
                busy                = 1'b1;
                mem.mem_write       = 1'b1;
                mem.mem_access_addr = dst_ptr_q;
                mem.mem_write_data  = mode_q ? fill_q : buf_q;
                if (abort || remaining_q == LEN_W'(1)) state_d = S_DONE;
                else if (mode_q)                       state_d = S_WR;
                else                                   state_d = S_RD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Transfer parameters, pointers and progress counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= 1'b0;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            buf_q       <= '0;
            words_done  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q      <= mode;
                        src_ptr_q   <= src_addr;
                        dst_ptr_q   <= dst_addr;
                        remaining_q <= length;
                        fill_q      <= fill_value;
                        words_done  <= '0;
                    end
                end
                S_RD: begin
                    // An aborted read is dropped rather than buffered.
                    if (!abort) buf_q <= mem.mem_read_data;
                end
                S_WR: begin
                    words_done  <= words_done + LEN_W'(1);
                    src_ptr_q   <= src_ptr_q + ADDR_W'(1);
                    dst_ptr_q   <= dst_ptr_q + ADDR_W'(1);
                    remaining_q <= remaining_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
